// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution output requantiser.
package conv_pkg;

    localparam int ACC_WIDTH = 48;
    localparam int OUT_WIDTH = 16;
    localparam int LANES     = 4;
    localparam int SUM_WIDTH = ACC_WIDTH + 1;

    localparam logic [OUT_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = 16'h8000;

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX_WIDE = 49'sd32767;
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN_WIDE = -49'sd32768;

    // Clamp a wide signed value to the output range; MSB of the result flags a clamp.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [SUM_WIDTH-1:0] v);
        logic [OUT_WIDTH:0] res;
        if (v > SAT_MAX_WIDE) begin
            res = {1'b1, SAT_MAX};
        end else if (v < SAT_MIN_WIDE) begin
            res = {1'b1, SAT_MIN};
        end else begin
            res = {1'b0, v[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-sample requantisation datapath: rounding shift, leaky-ReLU, saturation.
module requant_lane
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] in_data,
    input  logic                 in_last,
    input  logic [5:0]           shift_amt,
    input  logic                 leaky_en,
    input  logic [2:0]           leaky_shift,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 out_sat
);

    logic signed [SUM_WIDTH-1:0] acc_s;
    logic signed [SUM_WIDTH-1:0] rnd_s;
    logic signed [SUM_WIDTH-1:0] sum_s;
    logic signed [SUM_WIDTH-1:0] s1_next_s;
    logic signed [SUM_WIDTH-1:0] s2_next_s;
    logic        [OUT_WIDTH:0]   sat_res_s;

    logic                        s1_valid_r;
    logic                        s1_last_r;
    logic signed [SUM_WIDTH-1:0] s1_data_r;
    logic                        s1_leaky_r;
    logic        [2:0]           s1_lshift_r;
    logic                        s2_valid_r;
    logic                        s2_last_r;
    logic signed [SUM_WIDTH-1:0] s2_data_r;
    logic                        s3_valid_r;
    logic                        s3_last_r;
    logic        [OUT_WIDTH-1:0] s3_data_r;
    logic                        s3_sat_r;

    // S1: sign-extend and round-half-up right shift; the extra bit absorbs the rounding carry.
    always_comb begin
        acc_s = {in_data[ACC_WIDTH-1], in_data};
        if (shift_amt != 6'd0) begin
            rnd_s     = {{(SUM_WIDTH-1){1'b0}}, 1'b1} << (shift_amt - 6'd1);
            sum_s     = acc_s + rnd_s;
            s1_next_s = sum_s >>> shift_amt;
        end else begin
            rnd_s     = '0;
            sum_s     = acc_s;
            s1_next_s = acc_s;
        end
    end

    // S2: leaky-ReLU scales negative values by 2^-leaky_shift (flooring shift).
    always_comb begin
        if (s1_leaky_r && s1_data_r[SUM_WIDTH-1]) begin
            s2_next_s = s1_data_r >>> s1_lshift_r;
        end else begin
            s2_next_s = s1_data_r;
        end
    end

    // S3: clamp to the signed 16-bit output range.
    always_comb begin
        sat_res_s = saturate(s2_data_r);
    end

    // Three-stage pipeline; every stage holds while the downstream is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_data_r   <= '0;
            s1_leaky_r  <= 1'b0;
            s1_lshift_r <= 3'd0;
            s2_valid_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            s2_data_r   <= '0;
            s3_valid_r  <= 1'b0;
            s3_last_r   <= 1'b0;
            s3_data_r   <= '0;
            s3_sat_r    <= 1'b0;
        end else if (adv) begin
            s1_valid_r  <= in_valid;
            s1_last_r   <= in_last;
            s1_data_r   <= s1_next_s;
            s1_leaky_r  <= leaky_en;
            s1_lshift_r <= leaky_shift;
            s2_valid_r  <= s1_valid_r;
            s2_last_r   <= s1_last_r;
            s2_data_r   <= s2_next_s;
            s3_valid_r  <= s2_valid_r;
            s3_last_r   <= s2_last_r;
            s3_data_r   <= sat_res_s[OUT_WIDTH-1:0];
            s3_sat_r    <= sat_res_s[OUT_WIDTH];
        end
    end

    assign out_valid = s3_valid_r;
    assign out_data  = s3_data_r;
    assign out_last  = s3_last_r;
    assign out_sat   = s3_sat_r;

endmodule

// File: rtl/conv_output_requant.sv
// Requantises 48-bit accumulators to int16 and packs four samples per 64-bit beat.
module conv_output_requant
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  shift_amt,
    input  logic        leaky_en,
    input  logic [2:0]  leaky_shift,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic [15:0] sat_count
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    logic                 adv_s;
    logic                 accept_s;
    logic                 consume_s;
    logic                 unused_hi_s;
    logic                 first_beat_r;
    logic [5:0]           cfg_shift_r;
    logic                 cfg_leaky_r;
    logic [2:0]           cfg_lshift_r;
    logic [5:0]           eff_shift_s;
    logic                 eff_leaky_s;
    logic [2:0]           eff_lshift_s;
    logic                 lane_valid_s;
    logic [OUT_WIDTH-1:0] lane_data_s;
    logic                 lane_last_s;
    logic                 lane_sat_s;
    logic [IDX_W-1:0]     idx_r;
    logic [63:0]          pack_r;
    logic [63:0]          merged_s;
    logic [63:0]          out_data_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic                 frame_done_r;
    logic [15:0]          sat_count_r;

    // Handshake qualifiers: the whole pipeline moves only when the output slot can take a word.
    always_comb begin
        adv_s       = !out_valid_r || m_axis_tready;
        accept_s    = s_axis_tvalid && adv_s;
        consume_s   = adv_s && lane_valid_s;
        unused_hi_s = ^s_axis_tdata[63:ACC_WIDTH];
    end

    // The first beat of a frame uses the live config inputs; later beats use the latched copy.
    always_comb begin
        if (first_beat_r) begin
            eff_shift_s  = shift_amt;
            eff_leaky_s  = leaky_en;
            eff_lshift_s = leaky_shift;
        end else begin
            eff_shift_s  = cfg_shift_r;
            eff_leaky_s  = cfg_leaky_r;
            eff_lshift_s = cfg_lshift_r;
        end
    end

    // Latch the frame config on its first accepted beat and track frame boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_beat_r <= 1'b1;
            cfg_shift_r  <= 6'd0;
            cfg_leaky_r  <= 1'b0;
            cfg_lshift_r <= 3'd0;
        end else if (accept_s) begin
            first_beat_r <= s_axis_tlast;
            if (first_beat_r) begin
                cfg_shift_r  <= shift_amt;
                cfg_leaky_r  <= leaky_en;
                cfg_lshift_r <= leaky_shift;
            end
        end
    end

    requant_lane u_lane (
        .clk         (clk),
        .reset       (reset),
        .adv         (adv_s),
        .in_valid    (s_axis_tvalid),
        .in_data     (s_axis_tdata[ACC_WIDTH-1:0]),
        .in_last     (s_axis_tlast),
        .shift_amt   (eff_shift_s),
        .leaky_en    (eff_leaky_s),
        .leaky_shift (eff_lshift_s),
        .out_valid   (lane_valid_s),
        .out_data    (lane_data_s),
        .out_last    (lane_last_s),
        .out_sat     (lane_sat_s)
    );

    // Per-frame saturation counter: cleared by a frame's first beat, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_r <= 16'd0;
        end else if (accept_s && first_beat_r) begin
            sat_count_r <= 16'd0;
        end else if (consume_s && lane_sat_s && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end
    end

    // Insert the incoming sample into its lane of the word under construction.
    always_comb begin
        merged_s = pack_r;
        for (int l = 0; l < LANES; l++) begin
            if (idx_r == IDX_W'(l)) begin
                merged_s[l*OUT_WIDTH +: OUT_WIDTH] = lane_data_s;
            end else begin
                merged_s[l*OUT_WIDTH +: OUT_WIDTH] = pack_r[l*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Packer and output register; a full or frame-ending word is published and the build resets.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r       <= '0;
            pack_r      <= 64'd0;
            out_data_r  <= 64'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (adv_s) begin
            if (lane_valid_s) begin
                if ((idx_r == IDX_LAST) || lane_last_s) begin
                    out_data_r  <= merged_s;
                    out_valid_r <= 1'b1;
                    out_last_r  <= lane_last_s;
                    pack_r      <= 64'd0;
                    idx_r       <= '0;
                end else begin
                    pack_r      <= merged_s;
                    idx_r       <= idx_r + IDX_W'(1);
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            end else begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    // Frame completion pulse, one cycle after the last beat is taken downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && m_axis_tready && out_last_r;
        end
    end

    assign s_axis_tready = adv_s;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_last_r;
    assign frame_done    = frame_done_r;
    assign sat_count     = sat_count_r;

endmodule

// File: tb/tb_conv_output_requant.sv
// Randomised and directed bench for conv_output_requant with a behavioural reference model.
module tb_conv_output_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  shift_amt;
    logic        leaky_en;
    logic [2:0]  leaky_shift;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        frame_done;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    conv_output_requant dut (
        .clk           (clk),
        .reset         (reset),
        .shift_amt     (shift_amt),
        .leaky_en      (leaky_en),
        .leaky_shift   (leaky_shift),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .sat_count     (sat_count)
    );

    int checks   = 0;
    int failures = 0;
    int frames_done_seen = 0;

    logic [64:0] exp_q[$];     // {tlast, word}
    logic [63:0] dut_words[$];
    logic        dut_lasts[$];
    logic [47:0] fdata[$];

    bit rand_ready = 1'b0;
    bit force_low  = 1'b0;

    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_hs_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: round-half-up shift, leaky slope, clamp; returns {saturated, value}.
    function automatic logic [16:0] model(input logic [47:0] d, input int sh, input bit lk, input int ls);
        longint acc;
        longint r;
        acc = longint'($signed(d));
        if (sh > 0) r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = acc;
        if (lk && r < 0) r = r >>> ls;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, r[15:0]};
    endfunction

    // Push the expected packed words for the frame in fdata; returns the saturation count.
    function automatic int model_frame(input int sh, input bit lk, input int ls);
        int          nsat = 0;
        int          idx  = 0;
        logic [63:0] w    = 64'd0;
        logic [16:0] m;
        for (int i = 0; i < fdata.size(); i++) begin
            m = model(fdata[i], sh, lk, ls);
            if (m[16]) nsat++;
            w[idx*16 +: 16] = m[15:0];
            if (idx == 3 || i == fdata.size() - 1) begin
                exp_q.push_back({(i == fdata.size() - 1), w});
                w   = 64'd0;
                idx = 0;
            end else begin
                idx++;
            end
        end
        return nsat;
    endfunction

    task automatic send_beat(input logic [47:0] d, input logic last);
        int   n = 0;
        logic ok;
        s_axis_tdata  = {$urandom_range(65535, 0), d};
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
            if (n > 3000) begin
                $display("FAIL send_timeout actual=%0d required=<3000 cycles", n);
                failures++;
                $fatal(1, "input handshake never completed");
            end
        end while (!ok);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Drive fdata; beat 0 carries the real config, later beats carry junk or alternate config.
    task automatic drive_frame(input int sh, input bit lk, input int ls, input bit scramble,
                               input int alt_sh);
        for (int i = 0; i < fdata.size(); i++) begin
            if (i == 0) begin
                shift_amt = 6'(sh); leaky_en = lk; leaky_shift = 3'(ls);
            end else if (scramble) begin
                shift_amt   = 6'($urandom_range(47, 0));
                leaky_en    = 1'($urandom_range(1, 0));
                leaky_shift = 3'($urandom_range(7, 0));
            end else begin
                shift_amt = 6'(alt_sh);
            end
            send_beat(fdata[i], (i == fdata.size() - 1));
        end
    endtask

    task automatic finish_frame(input int base, input int nsat);
        int n = 0;
        while (frames_done_seen == base && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", 64'(frames_done_seen), 64'(base + 1));
        check("sat_count", {48'd0, sat_count}, 64'(nsat));
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int sh, input bit lk, input int ls, input bit scramble);
        int nsat;
        int base;
        base = frames_done_seen;
        nsat = model_frame(sh, lk, ls);
        drive_frame(sh, lk, ls, scramble, sh);
        finish_frame(base, nsat);
    endtask

    // Output-side ready generator, updated away from the sampling edge.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (force_low)       m_axis_tready = 1'b0;
            else if (rand_ready) m_axis_tready = ($urandom_range(3, 0) != 0);
            else                 m_axis_tready = 1'b1;
        end
    end

    // Compare process: handshake rules, stall stability, frame_done timing and scoreboard.
    always @(negedge clk) begin
        logic [64:0] e;
        if (reset) begin
            prev_stall   <= 1'b0;
            prev_hs_last <= 1'b0;
            prev_data    <= 64'd0;
        end else begin
            check("s_tready_rule", {63'd0, s_axis_tready}, {63'd0, (!m_axis_tvalid || m_axis_tready)});
            if (prev_stall) begin
                check("stall_valid_held", {63'd0, m_axis_tvalid}, 64'd1);
                check("stall_data_held", m_axis_tdata, prev_data);
            end
            check("frame_done_pulse", {63'd0, frame_done}, {63'd0, prev_hs_last});
            if (frame_done) frames_done_seen++;
            if (m_axis_tvalid && m_axis_tready) begin
                dut_words.push_back(m_axis_tdata);
                dut_lasts.push_back(m_axis_tlast);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_axis_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", m_axis_tdata, e[63:0]);
                    check("word_last", {63'd0, m_axis_tlast}, {63'd0, e[64]});
                end
            end
            prev_stall   <= m_axis_tvalid && !m_axis_tready;
            prev_data    <= m_axis_tdata;
            prev_hs_last <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
        end
    end

    initial begin
        int          base;
        int          nsat;
        logic [16:0] m;
        reset = 1'b1;
        shift_amt = 6'd0; leaky_en = 1'b0; leaky_shift = 3'd0;
        s_axis_tdata = 64'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_m_tdata", m_axis_tdata, 64'd0);
        check("rst_m_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_sat_count", {48'd0, sat_count}, 64'd0);
        check("rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
        @(posedge clk); #1; reset = 1'b0;

        // Pin the reference model with hand-computed values.
        m = model(48'h012380, 8, 0, 0);          check("model_round", {47'd0, m}, 64'h0124);
        m = model(48'h00007F, 8, 0, 0);          check("model_round_down", {47'd0, m}, 64'h0000);
        m = model(48'hFFFFFFFFF600, 8, 1, 3);    check("model_leaky", {47'd0, m}, 64'h0FFFE);
        m = model(48'hFFFFFFFFF600, 8, 0, 3);    check("model_noleaky", {47'd0, m}, 64'h0FFF6);
        m = model(48'h000010000000, 8, 0, 0);    check("model_satpos", {47'd0, m}, 64'h17FFF);

        // Basic packing and latency.
        fdata = '{48'h012380, 48'h000100, 48'h00007F, 48'h000080};
        base = frames_done_seen;
        nsat = model_frame(8, 0, 0);
        drive_frame(8, 0, 0, 0, 8);
        @(negedge clk); check("lat_k0", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge clk); check("lat_k1", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge clk); check("lat_k2", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge clk); check("lat_k3", {63'd0, m_axis_tvalid}, 64'd1);
        finish_frame(base, nsat);
        check("t1_word", dut_words[$], 64'h0001_0000_0001_0124);
        check("t1_last", {63'd0, dut_lasts[$]}, 64'd1);

        // Leaky-ReLU on and off, single-sample frames.
        fdata = '{48'hFFFFFFFFF600};
        run_frame(8, 1, 3, 0);
        check("t2_leaky", dut_words[$], 64'h0000_0000_0000_FFFE);
        run_frame(8, 0, 3, 0);
        check("t2_noleaky", dut_words[$], 64'h0000_0000_0000_FFF6);

        // Saturation both ways, then counter restart on a new frame.
        fdata = '{48'h000010000000, 48'hFFFFF0000000};
        run_frame(8, 0, 0, 0);
        check("t3_word", dut_words[$], 64'h0000_0000_8000_7FFF);
        fdata = '{48'h000100};
        run_frame(8, 0, 0, 0);

        // Six samples spill into a short second word.
        fdata = '{48'd1, 48'd2, 48'd3, 48'd4, 48'd5, 48'd6};
        run_frame(0, 0, 0, 0);
        check("t4_word0", dut_words[dut_words.size()-2], 64'h0004_0003_0002_0001);
        check("t4_last0", {63'd0, dut_lasts[dut_lasts.size()-2]}, 64'd0);
        check("t4_word1", dut_words[$], 64'h0000_0000_0006_0005);
        check("t4_last1", {63'd0, dut_lasts[$]}, 64'd1);

        // Output stall of 10 cycles inside a 256-sample frame.
        fdata.delete();
        for (int i = 0; i < 256; i++) fdata.push_back(48'(i * 37 - 4000));
        fork
            run_frame(2, 1, 1, 0);
            begin
                repeat (40) @(posedge clk);
                #1 force_low = 1'b1;
                repeat (5) @(negedge clk);
                check("stall_m_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                check("stall_s_tready", {63'd0, s_axis_tready}, 64'd0);
                repeat (5) @(posedge clk);
                #1 force_low = 1'b0;
            end
        join

        // A mid-frame shift change is ignored until the next frame.
        fdata = '{48'h000400, 48'h000400, 48'h000400, 48'h000400};
        base = frames_done_seen;
        nsat = model_frame(8, 0, 0);
        drive_frame(8, 0, 0, 0, 2);
        finish_frame(base, nsat);
        check("t6_word", dut_words[$], 64'h0004_0004_0004_0004);
        fdata = '{48'h000400};
        run_frame(2, 0, 0, 0);
        check("t6_next", dut_words[$], 64'h0000_0000_0000_0100);

        // Reset mid-frame: the full word escapes, the partial word is dropped.
        fdata = '{48'd7, 48'd8, 48'd9, 48'd10};
        nsat = model_frame(0, 0, 0);
        exp_q[$][64] = 1'b0;
        fdata = '{48'd7, 48'd8, 48'd9, 48'd10, 48'd11, 48'd12, 48'd13};
        shift_amt = 6'd0;
        for (int i = 0; i < 6; i++) send_beat(fdata[i], 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("mr_m_tdata", m_axis_tdata, 64'd0);
        check("mr_sat_count", {48'd0, sat_count}, 64'd0);
        check("mr_flushed", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        fdata = '{48'd21, 48'd22, 48'd23};
        run_frame(0, 0, 0, 0);
        check("mr_next", dut_words[$], 64'h0000_0017_0016_0015);

        // Randomised frames with random backpressure and junk mid-frame config.
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(40, 1);
            fdata.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1)
                    fdata.push_back({$urandom_range(65535, 0), 32'($urandom)});
                else
                    fdata.push_back(48'($signed(24'($urandom))));
            end
            run_frame($urandom_range(47, 0), 1'($urandom_range(1, 0)), $urandom_range(7, 0), 1'b1);
        end
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_output_requant.md
Name: conv_output_requant

Overview:
- Sits directly downstream of the convolution top; consumes its 64-bit AXI-Stream of 48-bit signed accumulator results.
- Per sample: rounding arithmetic right shift, optional leaky-ReLU, saturation to signed 16-bit.
- Packs four results per 64-bit output beat for the output DMA, preserving frame boundaries (tlast).

Parameters:
- ACC_WIDTH, 48, signed accumulator width held in s_axis_tdata[ACC_WIDTH-1:0].
- OUT_WIDTH, 16, signed output sample width.
- LANES, 4, samples packed per output beat (LANES*OUT_WIDTH = 64).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- shift_amt  in  6  requant right-shift amount, 0..47.
- leaky_en  in  1  enable leaky-ReLU on negative values.
- leaky_shift  in  3  leaky slope = 2^-leaky_shift.
- s_axis_tdata  in  64  accumulator; bits [63:ACC_WIDTH] ignored.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last result of frame.
- m_axis_tdata  out  64  packed samples; lane 0 in [15:0].
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of frame.
- frame_done  out  1  one-cycle pulse when the tlast beat is accepted downstream.
- sat_count  out  16  saturation events in the current frame; sticks at 0xFFFF.

Behaviour:
- Reset: all pipeline valids 0, lane index 0, m_axis_tvalid/tlast/tdata 0, frame_done 0, sat_count 0, config regs 0, first-beat flag 1.
- Advance enable adv = !m_axis_tvalid || m_axis_tready. s_axis_tready = adv, combinational; it is the only combinational in-to-out path. While !adv, every stage holds.
- Config latch: shift_amt, leaky_en and leaky_shift are registered on the first accepted beat of each frame (after reset, or after a tlast beat). Changes mid-frame have no effect. sat_count clears to 0 on that same beat.
- S1: acc = sext(tdata[47:0]). If shift_amt > 0, r = (acc + 2^(shift_amt-1)) >>> shift_amt (round half up); otherwise r = acc. Use a 49-bit intermediate; no overflow.
- S2: if leaky_en and r < 0, r = r >>> leaky_shift (floor). Otherwise unchanged.
- S3: saturate to [-32768, 32767]. Increment sat_count when clamping occurs.
- Packer: on adv with S3 valid, write the sample into lane idx, then idx++.
  - If idx == 3 or the sample carries tlast: load m_axis_tdata/tvalid/tlast and set idx = 0.
  - Unfilled lanes of a short (tlast) word are 0. Lanes of a new word start zeroed.
- Latency: 4th sample accepted at edge k gives m_axis_tvalid high after edge k+3. Full throughput is 1 sample/cycle.
- frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast, registered; it pulses the cycle after the handshake.
- Empty frame cannot occur: tlast always accompanies a data beat.
- Reset mid-frame drops all in-flight samples and partial words. The next beat is treated as a first beat.

Decomposition:
- Shared package conv_pkg holds: ACC_WIDTH, OUT_WIDTH, LANES, SAT_MAX = 16'h7FFF, SAT_MIN = 16'h8000.
- Sub-module requant_lane implements S1–S3: a single-sample datapath with valid and advance-enable inputs, plus a saturation flag output.
- The packer, config latch and counters stay in the top.

Test Plan:
- shift=8, leaky off. Inputs 0x12380, 0x100, 0x7F, 0x80 with tlast on the 4th → one word 0x0001_0000_0001_0124, tlast=1, frame_done pulses, sat_count=0.
- shift=8, leaky_en=1, leaky_shift=3. Input −2560 (0xFFFFFFFFF600) → lane value 0xFFFE. With leaky off → 0xFFF6.
- shift=8. Inputs 0x10000000 and −0x10000000 → 0x7FFF and 0x8000; sat_count=2. A new frame restarts sat_count at 0.
- Six samples 1..6 (shift=0), tlast on the 6th → words 0x0004_0003_0002_0001 (tlast=0) then 0x0000_0000_0006_0005 (tlast=1).
- m_axis_tready held low 10 cycles mid-stream → s_axis_tready low after m_axis_tvalid rises; m_axis_tdata stable; no sample lost or duplicated over a 256-sample frame.
- Change shift_amt mid-frame → it applies only from the next frame. Assert reset mid-frame → outputs 0; the next frame packs from lane 0.
